hs_parallel_inout_if: RTL and testbench

- Byte-wide parallel I/O port with 4-phase handshake on both sides.
- CPU bus side: chip select, read/write strobes, one address bit, tri-state 8-bit data bus.
- Peripheral side: one input channel fed by a serial receiver (dav_in_/rfd_in/byte_in) and one output channel feeding a serial transmitter (dav_out_/rfd_out/byte_out).
- The peripherals run on foreign clocks, so their handshake inputs are synchronized.

---
 rtl/hs_parallel_inout_if.sv | 224 ++++++++++++++++++++++
 tb/tb_hs_parallel_inout_if.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_parallel_inout_if.sv
// Byte-wide CPU port bridging two 4-phase handshake channels (receiver in, transmitter out).
// Define HS_PARALLEL_IRQ_EN to add the CTL register and the registered irq output.
module hs_parallel_inout_if #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       s_,
    input  logic       ior_,
    input  logic       iow_,
    input  logic       a0,
    inout  wire  [7:0] d7_d0,
    input  logic       dav_in_,
    output logic       rfd_in,
    input  logic [7:0] byte_in,
    output logic       dav_out_,
    input  logic       rfd_out,
    output logic [7:0] byte_out
`ifdef HS_PARALLEL_IRQ_EN
    ,
    output logic       irq
`endif
);

    typedef enum logic [1:0] {
        InEmpty = 2'd0,
        InFull  = 2'd1,
        InWait  = 2'd2
    } in_state_e;

    typedef enum logic [1:0] {
        OutIdle = 2'd0,
        OutDav  = 2'd1,
        OutAck  = 2'd2
    } out_state_e;

    // Handshake inputs from foreign clock domains; reset to the idle (high) level.
    logic [SYNC_STAGES-1:0] dav_sync_q;
    logic [SYNC_STAGES-1:0] rfd_sync_q;
    logic                   dav_in_s;
    logic                   rfd_out_s;

    always_ff @(posedge clock) begin
        if (reset) begin
            dav_sync_q <= '1;
            rfd_sync_q <= '1;
        end else begin
            dav_sync_q <= {dav_sync_q[SYNC_STAGES-2:0], dav_in_};
            rfd_sync_q <= {rfd_sync_q[SYNC_STAGES-2:0], rfd_out};
        end
    end

    assign dav_in_s  = dav_sync_q[SYNC_STAGES-1];
    assign rfd_out_s = rfd_sync_q[SYNC_STAGES-1];

    // Bus strobe decode and edge detection
    logic iow_q;
    logic rd_rbr_q;
    logic rd_sel;
    logic rd_rbr;
    logic wr_evt;
    logic wr_tbr;
    logic rd_end;

    assign rd_sel = ~s_ & ~ior_;
    assign rd_rbr = rd_sel & ~a0;
    assign wr_evt = ~s_ & ~iow_ & iow_q;
    assign wr_tbr = wr_evt & ~a0;
    assign rd_end = rd_rbr_q & ~rd_rbr;

    always_ff @(posedge clock) begin
        if (reset) begin
            iow_q    <= 1'b1;
            rd_rbr_q <= 1'b0;
        end else begin
            iow_q    <= iow_;
            rd_rbr_q <= rd_rbr;
        end
    end

    // Input channel
    in_state_e  in_state_q, in_state_d;
    logic [7:0] rbr_q, rbr_d;
    logic       fi_q, fi_d;
    logic       rfd_in_q, rfd_in_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            in_state_q <= InEmpty;
            rbr_q      <= 8'h00;
            fi_q       <= 1'b0;
            rfd_in_q   <= 1'b1;
        end else begin
            in_state_q <= in_state_d;
            rbr_q      <= rbr_d;
            fi_q       <= fi_d;
            rfd_in_q   <= rfd_in_d;
        end
    end

    always_comb begin
        in_state_d = in_state_q;
        rbr_d      = rbr_q;
        fi_d       = fi_q;
        rfd_in_d   = rfd_in_q;
        case (in_state_q)
            InEmpty: begin
                if (!dav_in_s) begin
                    rbr_d      = byte_in;
                    fi_d       = 1'b1;
                    rfd_in_d   = 1'b0;
                    in_state_d = InFull;
                end
            end
            InFull: begin
                if (rd_end) begin
                    fi_d       = 1'b0;
                    in_state_d = InWait;
                end
            end
            InWait: begin
                // rfd_in stays low until the receiver withdraws dav_in_
                if (dav_in_s) begin
                    rfd_in_d   = 1'b1;
                    in_state_d = InEmpty;
                end
            end
            default: begin
                in_state_d = InEmpty;
            end
        endcase
    end

    // Output channel
    out_state_e out_state_q, out_state_d;
    logic [7:0] tbr_q, tbr_d;
    logic       fo_q, fo_d;
    logic       dav_out_q, dav_out_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            out_state_q <= OutIdle;
            tbr_q       <= 8'h00;
            fo_q        <= 1'b1;
            dav_out_q   <= 1'b1;
        end else begin
            out_state_q <= out_state_d;
            tbr_q       <= tbr_d;
            fo_q        <= fo_d;
            dav_out_q   <= dav_out_d;
        end
    end

    always_comb begin
        out_state_d = out_state_q;
        tbr_d       = tbr_q;
        fo_d        = fo_q;
        dav_out_d   = dav_out_q;
        case (out_state_q)
            OutIdle: begin
                // Writes outside this state are dropped so byte_out stays stable
                if (wr_tbr) begin
                    tbr_d       = d7_d0;
                    fo_d        = 1'b0;
                    dav_out_d   = 1'b0;
                    out_state_d = OutDav;
                end
            end
            OutDav: begin
                if (!rfd_out_s) begin
                    dav_out_d   = 1'b1;
                    out_state_d = OutAck;
                end
            end
            OutAck: begin
                if (rfd_out_s) begin
                    fo_d        = 1'b1;
                    out_state_d = OutIdle;
                end
            end
            default: begin
                out_state_d = OutIdle;
            end
        endcase
    end

    // Optional interrupt logic and STS bit7 source
    logic sts_msb;

`ifdef HS_PARALLEL_IRQ_EN
    logic [1:0] ctl_q;
    logic       irq_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            ctl_q <= 2'b00;
            irq_q <= 1'b0;
        end else begin
            if (wr_evt && a0) begin
                ctl_q <= d7_d0[1:0];
            end
            irq_q <= (fi_q & ctl_q[0]) | (fo_q & ctl_q[1]);
        end
    end

    assign irq     = irq_q;
    assign sts_msb = irq_q;
`else
    assign sts_msb = 1'b0;
`endif

    // CPU read path
    logic [7:0] sts;
    logic [7:0] rd_data;

    assign sts     = {sts_msb, 1'b0, fo_q, 4'b0000, fi_q};
    assign rd_data = a0 ? sts : rbr_q;
    assign d7_d0   = rd_sel ? rd_data : 8'bzzzz_zzzz;

    assign rfd_in   = rfd_in_q;
    assign dav_out_ = dav_out_q;
    assign byte_out = tbr_q;

endmodule

// File: tb/tb_hs_parallel_inout_if.sv
// Bench for hs_parallel_inout_if: directed vector table, corner sequences, then
// randomized receiver/transmitter/CPU traffic checked against byte-order scoreboards.
module tb_hs_parallel_inout_if;

    localparam int NumRand = 24;
    localparam int Limit   = 2000;

    logic       clock = 1'b0;
    logic       reset;
    logic       s_;
    logic       ior_;
    logic       iow_;
    logic       a0;
    wire  [7:0] d7_d0;
    logic       dav_in_;
    logic       rfd_in;
    logic [7:0] byte_in;
    logic       dav_out_;
    logic       rfd_out;
    logic [7:0] byte_out;
    logic       drv_en;
    logic [7:0] drv_val;
`ifdef HS_PARALLEL_IRQ_EN
    logic       irq;
`endif

    assign d7_d0 = drv_en ? drv_val : 8'bzzzz_zzzz;

    hs_parallel_inout_if #(
        .SYNC_STAGES(2)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .s_       (s_),
        .ior_     (ior_),
        .iow_     (iow_),
        .a0       (a0),
        .d7_d0    (d7_d0),
        .dav_in_  (dav_in_),
        .rfd_in   (rfd_in),
        .byte_in  (byte_in),
        .dav_out_ (dav_out_),
        .rfd_out  (rfd_out),
        .byte_out (byte_out)
`ifdef HS_PARALLEL_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit abort  = 1'b0;

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    int rx_got  = 0;
    int tx_sent = 0;
    int tx_got  = 0;

    typedef enum int {OpRd, OpWr, OpWrNs, OpDav, OpRfd, OpWait, OpPins} op_e;

    typedef struct {
        op_e        op;
        logic       a0;
        logic [7:0] data;
        logic [7:0] exp;
        logic       exp_rfd;
        logic       exp_dav;
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        abort = 1'b1;
        $display("FAIL %s: no handshake response within %0d cycles", name, Limit);
    endtask

    function automatic vec_t mk(op_e op, logic a, logic [7:0] d, logic [7:0] e,
                                logic r, logic dv, string n);
        vec_t v;
        v.op = op; v.a0 = a; v.data = d; v.exp = e;
        v.exp_rfd = r; v.exp_dav = dv; v.name = n;
        return v;
    endfunction

    function automatic vec_t v_rd(logic a, logic [7:0] e, string n);
        return mk(OpRd, a, 8'h00, e, 1'b0, 1'b0, n);
    endfunction
    function automatic vec_t v_wr(logic a, logic [7:0] d);
        return mk(OpWr, a, d, 8'h00, 1'b0, 1'b0, "wr");
    endfunction
    function automatic vec_t v_dav(logic v, logic [7:0] b);
        return mk(OpDav, v, b, 8'h00, 1'b0, 1'b0, "dav");
    endfunction
    function automatic vec_t v_rfd(logic v);
        return mk(OpRfd, v, 8'h00, 8'h00, 1'b0, 1'b0, "rfd");
    endfunction
    function automatic vec_t v_wait(logic [7:0] n);
        return mk(OpWait, 1'b0, n, 8'h00, 1'b0, 1'b0, "wait");
    endfunction
    function automatic vec_t v_pins(logic r, logic dv, logic [7:0] b, string n);
        return mk(OpPins, 1'b0, 8'h00, b, r, dv, n);
    endfunction

    task automatic cpu_rd(input logic a, output logic [7:0] d);
        @(negedge clock);
        s_ = 1'b0; ior_ = 1'b0; a0 = a;
        #1 d = d7_d0;
        @(negedge clock);
        s_ = 1'b1; ior_ = 1'b1;
    endtask

    task automatic cpu_wr(input logic a, input logic [7:0] d, input logic sel);
        @(negedge clock);
        s_ = ~sel; iow_ = 1'b0; a0 = a; drv_en = 1'b1; drv_val = d;
        @(negedge clock);
        s_ = 1'b1; iow_ = 1'b1; drv_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; s_ = 1'b1; ior_ = 1'b1; iow_ = 1'b1; a0 = 1'b0;
        dav_in_ = 1'b1; rfd_out = 1'b1; byte_in = 8'h00; drv_en = 1'b0; drv_val = 8'h00;
        repeat (3) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic rx_agent();
        int t;
        logic [7:0] b;
        for (int i = 0; i < NumRand && !abort; i++) begin
            repeat ($urandom_range(0, 6)) @(negedge clock);
            b = 8'($urandom);
            rx_q.push_back(b);
            byte_in = b; dav_in_ = 1'b0;
            t = 0;
            while (rfd_in !== 1'b0 && t < Limit) begin @(negedge clock); t++; end
            if (t >= Limit) begin timeout("rx_rfd_fall"); break; end
            repeat ($urandom_range(0, 3)) @(negedge clock);
            dav_in_ = 1'b1;
            t = 0;
            while (rfd_in !== 1'b1 && t < Limit && !abort) begin @(negedge clock); t++; end
            if (t >= Limit) begin timeout("rx_rfd_rise"); break; end
        end
    endtask

    task automatic tx_agent();
        int t;
        logic [7:0] e;
        while (tx_got < NumRand && !abort) begin
            t = 0;
            while (dav_out_ !== 1'b0 && t < Limit && !abort) begin @(negedge clock); t++; end
            if (t >= Limit) begin timeout("tx_dav_fall"); break; end
            if (abort) break;
            chk1("rnd_tx_queue", tx_q.size() != 0, 1'b1);
            e = (tx_q.size() != 0) ? tx_q.pop_front() : 8'h00;
            chk8("rnd_byte_out", byte_out, e);
            tx_got++;
            repeat ($urandom_range(0, 5)) @(negedge clock);
            rfd_out = 1'b0;
            t = 0;
            while (dav_out_ !== 1'b1 && t < Limit) begin @(negedge clock); t++; end
            if (t >= Limit) begin timeout("tx_dav_rise"); break; end
            repeat ($urandom_range(0, 5)) @(negedge clock);
            rfd_out = 1'b1;
        end
    endtask

    task automatic cpu_agent();
        logic [7:0] sts;
        logic [7:0] d;
        logic [7:0] b;
        int iter = 0;
        while ((rx_got < NumRand || tx_sent < NumRand) && !abort) begin
            if (iter >= 4000) begin timeout("cpu_poll"); break; end
            iter++;
            cpu_rd(1'b1, sts);
            chk8("rnd_sts_zero_bits", sts & 8'h5E, 8'h00);
            if (sts[0]) begin
                cpu_rd(1'b0, d);
                chk1("rnd_rx_queue", rx_q.size() != 0, 1'b1);
                if (rx_q.size() != 0) chk8("rnd_rbr", d, rx_q.pop_front());
                rx_got++;
            end
            if (sts[5] && tx_sent < NumRand) begin
                b = 8'($urandom);
                tx_q.push_back(b);
                cpu_wr(1'b0, b, 1'b1);
                tx_sent++;
            end
            repeat ($urandom_range(0, 4)) @(negedge clock);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running, expected $finish earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;

        vecs.push_back(v_rd(1'b1, 8'h20, "sts_reset"));
        vecs.push_back(v_rd(1'b0, 8'h00, "rbr_reset"));
        vecs.push_back(v_pins(1'b1, 1'b1, 8'h00, "pins_reset"));
        vecs.push_back(v_dav(1'b0, 8'hA5));
        vecs.push_back(v_wait(8'd2));
        vecs.push_back(v_pins(1'b1, 1'b1, 8'h00, "rfd_in_early"));
        vecs.push_back(v_wait(8'd1));
        vecs.push_back(v_pins(1'b0, 1'b1, 8'h00, "rfd_in_latency"));
        vecs.push_back(v_rd(1'b1, 8'h21, "sts_full"));
        vecs.push_back(v_rd(1'b0, 8'hA5, "rbr_a5"));
        vecs.push_back(v_rd(1'b1, 8'h20, "sts_after_read"));
        vecs.push_back(v_pins(1'b0, 1'b1, 8'h00, "rfd_held_wait"));
        vecs.push_back(v_dav(1'b1, 8'hA5));
        vecs.push_back(v_wait(8'd4));
        vecs.push_back(v_pins(1'b1, 1'b1, 8'h00, "rfd_release"));
        vecs.push_back(v_wr(1'b0, 8'h3C));
        vecs.push_back(v_pins(1'b1, 1'b0, 8'h3C, "dav_out_low"));
        vecs.push_back(v_rd(1'b1, 8'h00, "sts_fo_busy"));
        vecs.push_back(v_wr(1'b0, 8'hFF));
        vecs.push_back(v_pins(1'b1, 1'b0, 8'h3C, "wr_while_busy"));
        vecs.push_back(v_rfd(1'b0));
        vecs.push_back(v_wait(8'd4));
        vecs.push_back(v_pins(1'b1, 1'b1, 8'h3C, "dav_out_release"));
        vecs.push_back(v_rd(1'b1, 8'h00, "sts_out_ack"));
        vecs.push_back(v_rfd(1'b1));
        vecs.push_back(v_wait(8'd4));
        vecs.push_back(v_rd(1'b1, 8'h20, "sts_out_idle"));
        vecs.push_back(mk(OpWrNs, 1'b0, 8'h77, 8'h00, 1'b0, 1'b0, "wr_ns"));
        vecs.push_back(v_pins(1'b1, 1'b1, 8'h3C, "wr_masked"));
        vecs.push_back(v_rd(1'b1, 8'h20, "sts_masked"));
        vecs.push_back(v_wr(1'b0, 8'hC7));
        vecs.push_back(v_pins(1'b1, 1'b0, 8'hC7, "dav_out_c7"));
        vecs.push_back(v_dav(1'b0, 8'hA5));
        vecs.push_back(v_wait(8'd5));
        vecs.push_back(v_pins(1'b0, 1'b0, 8'hC7, "rx2_first"));
        vecs.push_back(v_dav(1'b1, 8'hA5));
        vecs.push_back(v_wait(8'd4));
        vecs.push_back(v_dav(1'b0, 8'h5A));
        vecs.push_back(v_wait(8'd6));
        vecs.push_back(v_pins(1'b0, 1'b0, 8'hC7, "no_overrun"));
        vecs.push_back(v_rd(1'b1, 8'h01, "sts_full_busy"));
        vecs.push_back(v_rd(1'b0, 8'hA5, "rbr_kept"));
        vecs.push_back(v_rd(1'b1, 8'h00, "sts_wait_busy"));
        vecs.push_back(v_pins(1'b0, 1'b0, 8'hC7, "rfd_wait"));
        vecs.push_back(v_dav(1'b1, 8'h5A));
        vecs.push_back(v_wait(8'd4));
        vecs.push_back(v_pins(1'b1, 1'b0, 8'hC7, "rfd_again"));
        vecs.push_back(v_dav(1'b0, 8'h5A));
        vecs.push_back(v_wait(8'd5));
        vecs.push_back(v_rd(1'b1, 8'h01, "sts_full2"));
        vecs.push_back(v_rd(1'b0, 8'h5A, "rbr_5a"));
        vecs.push_back(v_rd(1'b0, 8'h5A, "rbr_stale"));
        vecs.push_back(v_rd(1'b1, 8'h00, "sts_stale"));
        vecs.push_back(v_pins(1'b0, 1'b0, 8'hC7, "stale_no_change"));
        vecs.push_back(v_dav(1'b1, 8'h5A));
        vecs.push_back(v_wait(8'd4));
        vecs.push_back(v_rfd(1'b0));
        vecs.push_back(v_wait(8'd4));
        vecs.push_back(v_rfd(1'b1));
        vecs.push_back(v_wait(8'd4));
        vecs.push_back(v_rd(1'b1, 8'h20, "sts_idle_end"));
        vecs.push_back(v_pins(1'b1, 1'b1, 8'hC7, "pins_idle_end"));

        do_reset();
        chk1("rfd_in_after_reset", rfd_in, 1'b1);
        chk1("dav_out_after_reset", dav_out_, 1'b1);

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OpRd: begin
                    cpu_rd(vecs[i].a0, d);
                    chk8(vecs[i].name, d, vecs[i].exp);
                end
                OpWr:   cpu_wr(vecs[i].a0, vecs[i].data, 1'b1);
                OpWrNs: cpu_wr(vecs[i].a0, vecs[i].data, 1'b0);
                OpDav: begin
                    @(negedge clock);
                    byte_in = vecs[i].data; dav_in_ = vecs[i].a0;
                end
                OpRfd: begin
                    @(negedge clock);
                    rfd_out = vecs[i].a0;
                end
                OpWait: repeat (int'(vecs[i].data)) @(negedge clock);
                OpPins: begin
                    chk1({vecs[i].name, "_rfd_in"}, rfd_in, vecs[i].exp_rfd);
                    chk1({vecs[i].name, "_dav_out"}, dav_out_, vecs[i].exp_dav);
                    chk8({vecs[i].name, "_byte_out"}, byte_out, vecs[i].exp);
                end
                default: ;
            endcase
        end

        // Bus must float unless selected with a read strobe
        @(negedge clock);
        s_ = 1'b1; ior_ = 1'b0; a0 = 1'b0; drv_en = 1'b1; drv_val = 8'h00;
        #1 chk8("hiz_unselected", d7_d0, 8'h00);
        s_ = 1'b0; ior_ = 1'b1; a0 = 1'b1;
        #1 chk8("hiz_no_strobe", d7_d0, 8'h00);
        s_ = 1'b1; drv_en = 1'b0; a0 = 1'b0;

        cpu_wr(1'b1, 8'h03, 1'b1);
        cpu_rd(1'b1, d);
`ifdef HS_PARALLEL_IRQ_EN
        chk8("sts_irq", d, 8'hA0);
        chk1("irq_pin", irq, 1'b1);
`else
        chk8("sts_ctl_ignored", d, 8'h20);
`endif
        chk1("ctl_wr_dav", dav_out_, 1'b1);
        chk8("ctl_wr_byte_out", byte_out, 8'hC7);
        cpu_wr(1'b1, 8'h00, 1'b1);
        repeat (2) @(negedge clock);
        cpu_rd(1'b1, d);
        chk8("sts_irq_off", d, 8'h20);

        // Reset in the middle of both handshakes
        cpu_wr(1'b0, 8'h44, 1'b1);
        chk1("dav_before_reset", dav_out_, 1'b0);
        chk8("byte_before_reset", byte_out, 8'h44);
        byte_in = 8'hC3; dav_in_ = 1'b0;
        repeat (4) @(negedge clock);
        chk1("rfd_before_reset", rfd_in, 1'b0);
        reset = 1'b1; dav_in_ = 1'b1;
        @(negedge clock);
        chk1("reset_dav_out", dav_out_, 1'b1);
        chk1("reset_rfd_in", rfd_in, 1'b1);
        chk8("reset_byte_out", byte_out, 8'h00);
        reset = 1'b0;
        cpu_rd(1'b1, d);
        chk8("reset_sts", d, 8'h20);
        cpu_rd(1'b0, d);
        chk8("reset_rbr", d, 8'h00);

        do_reset();
        fork
            rx_agent();
            tx_agent();
            cpu_agent();
        join
        chk_int("rnd_rx_count", rx_got, NumRand);
        chk_int("rnd_tx_count", tx_got, NumRand);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
